dram_device_model: RTL

//  Cycle-accurate responder for the DRAM command-pin interface driven by the AXI-side DRAM controller.

---
 rtl/dram_pkg.sv | 29 ++
 rtl/dram_rd_pipe.sv | 31 +++
 rtl/dram_device_model.sv | 119 +++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared command/state encodings, default timing and the command-pin decoder
// for the DRAM device model.
package dram_pkg;

  typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_PRE, CMD_RD, CMD_WR, CMD_ILL} dram_cmd_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVATING, ST_ACTIVE, ST_PRECHARGING} state_e;

  localparam int DEF_CAS_LAT = 5;
  localparam int DEF_T_RCD   = 3;
  localparam int DEF_T_RP    = 3;

  // wen_none: all byte enables high (no write); wen_all: all byte enables low.
  function automatic dram_cmd_e dram_decode(input logic csn, input logic rasn,
                                            input logic casn, input logic wen_none,
                                            input logic wen_all);
    dram_cmd_e c;
    c = CMD_NOP;
    if (!csn) begin
      case ({rasn, casn})
        2'b01:   c = wen_none ? CMD_ACT : (wen_all ? CMD_PRE : CMD_ILL);
        2'b10:   c = wen_none ? CMD_RD : CMD_WR;
        2'b00:   c = CMD_ILL;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_rd_pipe.sv
// Read-latency pipe: stage 0 captures the word read at the command edge, so
// the last stage presents it STAGES cycles later. Data is zeroed when invalid.
module dram_rd_pipe #(
  parameter int DATA_BITS = 32,
  parameter int STAGES    = 5
)(
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 in_vld,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 out_vld,
  output logic [DATA_BITS-1:0] out_data
);

  logic [STAGES:0]                vld_pipe;
  logic [STAGES:0][DATA_BITS-1:0] dat_pipe;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_vld};
      dat_pipe <= {dat_pipe[STAGES-1:0], (in_vld ? in_data : {DATA_BITS{1'b0}})};
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_data = dat_pipe[STAGES];

endmodule

// File: rtl/dram_device_model.sv
// Cycle-accurate DRAM command-pin responder: single open row, tRCD/tRP
// enforcement, byte-masked writes and CAS-latency read return.
module dram_device_model
  import dram_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ROW_BITS  = 11,
  parameter int COL_BITS  = 10,
  parameter int CAS_LAT   = DEF_CAS_LAT,
  parameter int T_RCD     = DEF_T_RCD,
  parameter int T_RP      = DEF_T_RP,
  parameter int LANES     = DATA_BITS / 8,
  parameter int A_BITS    = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS
)(
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 DRAM_CSn,
  input  logic                 DRAM_RASn,
  input  logic                 DRAM_CASn,
  input  logic [LANES-1:0]     DRAM_WEn,
  input  logic [A_BITS-1:0]    DRAM_A,
  input  logic [DATA_BITS-1:0] DRAM_D,
  output logic [DATA_BITS-1:0] DRAM_Q,
  output logic                 DRAM_valid,
  output logic [ROW_BITS-1:0]  open_row,
  output logic                 row_open,
  output logic                 proto_err
);

  localparam int IDX_BITS = ROW_BITS + COL_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;

  state_e                 state;
  logic [2:0]             cnt;
  logic [2:0]             cnt_inc;
  dram_cmd_e              cmd;
  logic                   acc_rd, acc_wr;
  logic [IDX_BITS-1:0]    idx;
  logic [DATA_BITS-1:0]   rd_word;
  logic [DATA_BITS-1:0]   mem [DEPTH];

  assign cmd     = dram_decode(DRAM_CSn, DRAM_RASn, DRAM_CASn, &DRAM_WEn, ~|DRAM_WEn);
  assign cnt_inc = cnt + 3'd1;
  assign acc_rd  = (state == ST_ACTIVE) && (cmd == CMD_RD);
  assign acc_wr  = (state == ST_ACTIVE) && (cmd == CMD_WR);
  assign idx     = {open_row, DRAM_A[COL_BITS-1:0]};
  assign rd_word = mem[idx];

  // Promotion happens on the edge where the incremented count reaches the
  // limit, so a command exactly T_RCD/T_RP edges later is already legal.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      open_row  <= '0;
      row_open  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (cmd == CMD_ILL) proto_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cmd == CMD_ACT) begin
            open_row <= DRAM_A[ROW_BITS-1:0];
            cnt      <= 3'd1;
            state    <= (T_RCD <= 1) ? ST_ACTIVE : ST_ACTIVATING;
            row_open <= 1'b1;
          end else if (cmd == CMD_RD || cmd == CMD_WR) begin
            proto_err <= 1'b1;
          end
        end
        ST_ACTIVATING: begin
          if (cmd == CMD_PRE) begin
            cnt      <= 3'd1;
            state    <= (T_RP <= 1) ? ST_IDLE : ST_PRECHARGING;
            row_open <= 1'b0;
          end else begin
            if (cmd == CMD_ACT || cmd == CMD_RD || cmd == CMD_WR) proto_err <= 1'b1;
            cnt <= cnt_inc;
            if (int'(cnt_inc) >= T_RCD) state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (cmd == CMD_PRE) begin
            cnt      <= 3'd1;
            state    <= (T_RP <= 1) ? ST_IDLE : ST_PRECHARGING;
            row_open <= 1'b0;
          end else if (cmd == CMD_ACT) begin
            proto_err <= 1'b1;
          end
        end
        ST_PRECHARGING: begin
          if (cmd == CMD_ACT || cmd == CMD_RD || cmd == CMD_WR) proto_err <= 1'b1;
          cnt <= cnt_inc;
          if (int'(cnt_inc) >= T_RP) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array contents survive reset on purpose.
  always_ff @(posedge ACLK) begin
    if (acc_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (!DRAM_WEn[i]) mem[idx][8*i +: 8] <= DRAM_D[8*i +: 8];
      end
    end
  end

  dram_rd_pipe #(.DATA_BITS(DATA_BITS), .STAGES(CAS_LAT)) u_rd_pipe (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .in_vld   (acc_rd),
    .in_data  (rd_word),
    .out_vld  (DRAM_valid),
    .out_data (DRAM_Q)
  );

endmodule
